gppcu_wb_arbiter: RTL and testbench
===================================

Name: gppcu_wb_arbiter

Overview:
- Shares the single GPPCU register-file write port among NUM_REQ functional units (ALU, MUL, LSU, host).
- Round-robin grant, one write per cycle, one registered output stage.
- The same committed write drives the scoreboard release (write-register index plus valid) into the stall generator, so a register is released exactly when its data is written.
- Sits between the functional-unit result buses and the register file / stall generator.

Parameters:
- NUM_REQ, 4, number of requesting units (2..8)
- NUMREG, 32, number of architectural registers
- REGW, 5, register index width, equal to clog2(NUMREG)
- DATAW, 32, write data width
- CNTW, 16, width of the saturating conflict counter

Ports:
- iACLK  in  1  clock
- inRST  in  1  reset; asynchronous, active-low
- iREQ_VALID  in  NUM_REQ  per-unit write request
- oREQ_READY  out  NUM_REQ  per-unit grant; one-hot or zero
- iREQ_REG  in  NUM_REQ*REGW  packed destination indices; unit k at bits [k*REGW +: REGW]
- iREQ_DATA  in  NUM_REQ*DATAW  packed write data, same packing
- iWB_STALL  in  1  register-file port busy; hold the output stage
- oWR_EN  out  1  register-file write enable
- oWR_REG  out  REGW  register-file write index
- oWR_DATA  out  DATAW  register-file write data
- oWRREG  out  REGW  scoreboard release index (equal to oWR_REG)
- oWRREG_VALID  out  1  scoreboard release strobe (equal to oWR_EN)
- oGRANT_ID  out  clog2(NUM_REQ)  source unit of the entry in the output stage
- oCONFLICT_CNT  out  CNTW  cycles in which more than one request was valid

Behaviour:
- Reset (inRST low, asynchronous): output-stage valid outv=0, round-robin pointer ptr=0, oWR_REG/oWR_DATA/oGRANT_ID=0, oCONFLICT_CNT=0. Hence oWR_EN=0, oWRREG_VALID=0, oREQ_READY=0.
- Reset asserted mid-operation: the in-flight output entry is dropped without a write. Upstream units and the scoreboard are reset together.
- Output stage: oWR_EN = outv & ~iWB_STALL. The stage advances when ~outv | ~iWB_STALL (accept condition).
- Arbitration (combinational, evaluated every cycle):
  - Winner w = first k with iREQ_VALID[k], scanning ptr, ptr+1, … modulo NUM_REQ.
  - oREQ_READY[w] = accept condition & any valid; all other ready bits are 0.
  - Ready never depends on a ready of the same cycle (no loops).
- Handshake: a transfer occurs for unit k when iREQ_VALID[k] & oREQ_READY[k]. Units hold valid/reg/data stable until granted.
- On transfer (rising edge):
  - outv=1; oWR_REG, oWR_DATA ← unit w fields; oGRANT_ID=w.
  - ptr ← (w+1) mod NUM_REQ.
- Accept with no valid requests: outv ← 0; ptr unchanged.
- Latency: a request granted in cycle N is written (oWR_EN=1) in cycle N+1 if iWB_STALL=0. Throughput is 1 write per cycle.
- iWB_STALL=1 with outv=1: the output stage holds, oWR_EN=0, all ready bits 0, ptr unchanged.
- Scoreboard release: oWRREG=oWR_REG, oWRREG_VALID=oWR_EN in the same cycle, never earlier.
- Two requesters targeting the same register: serviced in round-robin order, one write each. No merging; the later grant overwrites.
- Conflict counter: +1 on each cycle with popcount(iREQ_VALID) ≥ 2 (independent of stall); saturates at 2^CNTW−1.
- No request is dropped. With iWB_STALL eventually low, each valid requester is granted within NUM_REQ grants.

Decomposition:
- Package gppcu_pkg: constants GPPCU_NUMREG=32, GPPCU_REGW=5, GPPCU_DATAW=32; functional-unit ID constants (FU_ALU=0, FU_MUL=1, FU_LSU=2, FU_HOST=3).
- One sub-module, gppcu_rr_arbiter: parameterised N-way round-robin arbiter with inputs req, advance, and outputs one-hot grant and encoded index; it owns ptr.
- The top level holds the output stage, the muxing and the counter.

Test Plan:
- Reset/idle: pulse inRST low mid-cycle with outv=1 → outputs clear immediately; no oWR_EN afterwards; oCONFLICT_CNT=0.
- Single requester: unit 2 valid, reg=7, data=0xDEADBEEF in cycle 0 → oREQ_READY=4'b0100 in cycle 0; cycle 1 oWR_EN=1, oWR_REG=7, oWR_DATA=0xDEADBEEF, oWRREG_VALID=1, oGRANT_ID=2.
- Fairness: all 4 units valid continuously, 8 cycles → grant order 0,1,2,3,0,1,2,3; oCONFLICT_CNT=8.
- Stall: grant unit 1 (reg 3), then iWB_STALL=1 for 3 cycles → oWR_EN=0 and ready=0 during stall, outputs held; write of reg 3 occurs the cycle stall drops; the next grant follows in that same cycle.
- Same-register collision: units 0 and 3 both target reg 5 with data 0x11 and 0x33, ptr=3 → writes 0x33 then 0x11 on consecutive cycles; two oWRREG_VALID pulses for reg 5.
- Counter saturation: CNTW=4, 20 conflict cycles → oCONFLICT_CNT stays at 15.

Source files
------------

// File: rtl/gppcu_pkg.sv
// gppcu_pkg: shared GPPCU register-file geometry and functional-unit identifiers.
package gppcu_pkg;
  localparam int GPPCU_NUMREG = 32;
  localparam int GPPCU_REGW = 5;
  localparam int GPPCU_DATAW = 32;
  typedef enum logic [1:0] {FU_ALU = 2'd0, FU_MUL = 2'd1, FU_LSU = 2'd2, FU_HOST = 2'd3} fu_e;
endpackage

// File: rtl/gppcu_rr_arbiter.sv
// gppcu_rr_arbiter: N-way round-robin arbiter; the pointer moves past the winner only when a grant is taken.
module gppcu_rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW-1:0] ptr, k;
  // Scan from the far end back to ptr so the last hit is the first requester at or after ptr.
  always_comb begin
    idx = '0;
    k = '0;
    for (int i = N - 1; i >= 0; i--) begin
      k = IW'((int'(ptr) + i) % N);
      if (req[k]) idx = k;
    end
  end
  assign any = |req;
  assign grant = (advance && any) ? N'(1) << idx : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= '0;
    else if (advance && any) ptr <= (int'(idx) == N - 1) ? '0 : idx + 1'b1;
  end
endmodule

// File: rtl/gppcu_wb_arbiter.sv
// gppcu_wb_arbiter: shares the register-file write port among functional units;
// the committed write also serves as the scoreboard release.
module gppcu_wb_arbiter import gppcu_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int NUMREG = GPPCU_NUMREG,
  parameter int REGW = GPPCU_REGW,
  parameter int DATAW = GPPCU_DATAW,
  parameter int CNTW = 16,
  localparam int GW = $clog2(NUM_REQ)
) (
  input  logic                     iACLK,
  input  logic                     inRST,
  input  logic [NUM_REQ-1:0]       iREQ_VALID,
  output logic [NUM_REQ-1:0]       oREQ_READY,
  input  logic [NUM_REQ*REGW-1:0]  iREQ_REG,
  input  logic [NUM_REQ*DATAW-1:0] iREQ_DATA,
  input  logic                     iWB_STALL,
  output logic                     oWR_EN,
  output logic [REGW-1:0]          oWR_REG,
  output logic [DATAW-1:0]         oWR_DATA,
  output logic [REGW-1:0]          oWRREG,
  output logic                     oWRREG_VALID,
  output logic [GW-1:0]            oGRANT_ID,
  output logic [CNTW-1:0]          oCONFLICT_CNT
);
  if (REGW != $clog2(NUMREG)) begin : g_regw_check
    $error("REGW must equal clog2(NUMREG)");
  end
  logic outv, accept, any, multi;
  logic [GW-1:0] idx;
  assign accept = ~outv | ~iWB_STALL;
  assign multi = |(iREQ_VALID & (iREQ_VALID - 1'b1));
  gppcu_rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk(iACLK),
    .rst_n(inRST),
    .req(iREQ_VALID),
    .advance(accept),
    .grant(oREQ_READY),
    .idx(idx),
    .any(any)
  );
  always_ff @(posedge iACLK or negedge inRST) begin
    if (!inRST) begin
      outv <= 1'b0;
      oWR_REG <= '0;
      oWR_DATA <= '0;
      oGRANT_ID <= '0;
      oCONFLICT_CNT <= '0;
    end else begin
      if (accept) outv <= any;
      if (accept && any) begin
        oWR_REG <= iREQ_REG[idx*REGW +: REGW];
        oWR_DATA <= iREQ_DATA[idx*DATAW +: DATAW];
        oGRANT_ID <= idx;
      end
      if (multi && ~&oCONFLICT_CNT) oCONFLICT_CNT <= oCONFLICT_CNT + 1'b1;
    end
  end
  assign oWR_EN = outv & ~iWB_STALL;
  assign oWRREG = oWR_REG;
  assign oWRREG_VALID = oWR_EN;
endmodule

// File: tb/tb_gppcu_wb_arbiter.sv
// tb_gppcu_wb_arbiter: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_gppcu_wb_arbiter;
  import gppcu_pkg::*;
  localparam int N = 4, RW = 5, DW = 32, CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0, rst_n = 1'b0, stall = 1'b0;
  logic [N-1:0] valid = '0, ready;
  logic [N-1:0][RW-1:0] regs = '0;
  logic [N-1:0][DW-1:0] dat = '0;
  logic wr_en, wrreg_valid;
  logic [RW-1:0] wr_reg, wrreg;
  logic [DW-1:0] wr_data;
  logic [1:0] gid;
  logic [CW-1:0] cnt;
  int n_tests = 0, n_fail = 0;
  typedef struct {logic [RW-1:0] r; logic [DW-1:0] d; int id;} wr_t;
  wr_t sb[$];
  bit m_outv;
  int m_ptr, m_cnt;

  gppcu_wb_arbiter #(.NUM_REQ(N), .NUMREG(32), .REGW(RW), .DATAW(DW), .CNTW(CW)) dut (
    .iACLK(clk), .inRST(rst_n), .iREQ_VALID(valid), .oREQ_READY(ready),
    .iREQ_REG(regs), .iREQ_DATA(dat), .iWB_STALL(stall), .oWR_EN(wr_en),
    .oWR_REG(wr_reg), .oWR_DATA(wr_data), .oWRREG(wrreg), .oWRREG_VALID(wrreg_valid),
    .oGRANT_ID(gid), .oCONFLICT_CNT(cnt)
  );

  always #5 clk = ~clk;

  function automatic int winner();
    int k;
    for (int i = 0; i < N; i++) begin
      k = (m_ptr + i) % N;
      if (valid[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int w;
    w = winner();
    return ((!m_outv || !stall) && w >= 0) ? N'(1) << w : '0;
  endfunction

  task automatic model_reset();
    m_outv = 0;
    m_ptr = 0;
    m_cnt = 0;
    sb.delete();
  endtask

  task automatic model_edge();
    int w;
    w = winner();
    if ($countones(valid) >= 2 && m_cnt < CMAX) m_cnt++;
    if (!m_outv || !stall) begin
      if (w >= 0) begin
        m_outv = 1;
        sb.push_back('{regs[w], dat[w], w});
        m_ptr = (w + 1) % N;
      end else m_outv = 0;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    valid = '0;
    stall = 0;
    rst_n = 0;
    #2;
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++; if (wr_en !== 1'b0 || wrreg_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b/%b expected 0/0", wr_en, wrreg_valid); end
    n_tests++; if (ready !== '0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", ready); end
    n_tests++; if (cnt !== '0 || gid !== '0 || wr_reg !== '0) begin n_fail++; $display("FAIL reset_regs: got cnt=%0d gid=%0d reg=%0d expected 0", cnt, gid, wr_reg); end
    @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
    valid = 4'b0001; regs[0] = 9; dat[0] = 32'hAA;
    @(negedge clk);
    tick();
    valid = '0; stall = 1;
    @(negedge clk);
    n_tests++; if (wr_reg !== 5'd9 || wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_held: got reg=%0d en=%b expected 9/0", wr_reg, wr_en); end
    #2 rst_n = 0;
    #1;
    n_tests++; if (wr_reg !== '0 || wr_data !== '0 || wr_en !== 1'b0 || ready !== '0) begin n_fail++; $display("FAIL async_reset: got reg=%0d data=%h en=%b rdy=%b expected 0", wr_reg, wr_data, wr_en, ready); end
    stall = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
    @(negedge clk);
    n_tests++; if (wr_en !== 1'b0 || cnt !== '0) begin n_fail++; $display("FAIL post_reset: got en=%b cnt=%0d expected 0/0", wr_en, cnt); end
    tick();
  endtask

  task automatic test_single();
    do_reset();
    valid = 4'b0100; regs[2] = 7; dat[2] = 32'hDEADBEEF;
    @(negedge clk);
    n_tests++; if (ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b expected 0100", ready); end
    tick();
    valid = '0;
    @(negedge clk);
    n_tests++; if (wr_en !== 1'b1 || wrreg_valid !== 1'b1) begin n_fail++; $display("FAIL single_en: got %b/%b expected 1/1", wr_en, wrreg_valid); end
    n_tests++; if (wr_reg !== 5'd7 || wrreg !== 5'd7) begin n_fail++; $display("FAIL single_reg: got %0d/%0d expected 7", wr_reg, wrreg); end
    n_tests++; if (wr_data !== 32'hDEADBEEF || gid !== 2'd2) begin n_fail++; $display("FAIL single_data: got %h id %0d expected deadbeef id 2", wr_data, gid); end
    tick();
  endtask

  task automatic test_fairness();
    do_reset();
    valid = 4'b1111;
    for (int k = 0; k < N; k++) begin regs[k] = RW'(k + 10); dat[k] = DW'(k); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_tests++; if (ready !== N'(1) << (i % N)) begin n_fail++; $display("FAIL fair_ready[%0d]: got %b expected %b", i, ready, N'(1) << (i % N)); end
      if (i > 0) begin
        n_tests++; if (wr_en !== 1'b1 || gid !== 2'((i - 1) % N)) begin n_fail++; $display("FAIL fair_write[%0d]: got en=%b id=%0d expected 1 id=%0d", i, wr_en, gid, (i - 1) % N); end
      end
      tick();
    end
    valid = '0;
    @(negedge clk);
    n_tests++; if (cnt !== CW'(8)) begin n_fail++; $display("FAIL fair_cnt: got %0d expected 8", cnt); end
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    valid = 4'b0010; regs[1] = 3; dat[1] = 32'h1234;
    @(negedge clk);
    n_tests++; if (ready !== 4'b0010) begin n_fail++; $display("FAIL stall_grant: got %b expected 0010", ready); end
    tick();
    valid = 4'b0100; regs[2] = 9; dat[2] = 32'h5678; stall = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++; if (wr_en !== 1'b0 || ready !== '0 || wr_reg !== 5'd3 || gid !== 2'd1) begin n_fail++; $display("FAIL stall_hold[%0d]: got en=%b rdy=%b reg=%0d id=%0d expected 0/0000/3/1", i, wr_en, ready, wr_reg, gid); end
      tick();
    end
    stall = 0;
    @(negedge clk);
    n_tests++; if (wr_en !== 1'b1 || wr_reg !== 5'd3 || ready !== 4'b0100) begin n_fail++; $display("FAIL stall_release: got en=%b reg=%0d rdy=%b expected 1/3/0100", wr_en, wr_reg, ready); end
    tick();
    valid = '0;
    @(negedge clk);
    n_tests++; if (wr_en !== 1'b1 || wr_reg !== 5'd9 || wr_data !== 32'h5678) begin n_fail++; $display("FAIL stall_next: got en=%b reg=%0d data=%h expected 1/9/5678", wr_en, wr_reg, wr_data); end
    tick();
  endtask

  task automatic test_collision();
    do_reset();
    valid = 4'b0100; regs[2] = 1;
    @(negedge clk);
    tick();
    valid = 4'b1001; regs[0] = 5; regs[3] = 5; dat[0] = 32'h11; dat[3] = 32'h33;
    @(negedge clk);
    n_tests++; if (ready !== 4'b1000) begin n_fail++; $display("FAIL coll_first: got %b expected 1000", ready); end
    tick();
    valid = 4'b0001;
    @(negedge clk);
    n_tests++; if (ready !== 4'b0001) begin n_fail++; $display("FAIL coll_second: got %b expected 0001", ready); end
    n_tests++; if (wrreg_valid !== 1'b1 || wrreg !== 5'd5 || wr_data !== 32'h33) begin n_fail++; $display("FAIL coll_write1: got v=%b reg=%0d data=%h expected 1/5/33", wrreg_valid, wrreg, wr_data); end
    tick();
    valid = '0;
    @(negedge clk);
    n_tests++; if (wrreg_valid !== 1'b1 || wrreg !== 5'd5 || wr_data !== 32'h11) begin n_fail++; $display("FAIL coll_write2: got v=%b reg=%0d data=%h expected 1/5/11", wrreg_valid, wrreg, wr_data); end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    valid = 4'b0011;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_tests++; if (cnt !== CW'(i < CMAX ? i : CMAX)) begin n_fail++; $display("FAIL sat_cnt[%0d]: got %0d expected %0d", i, cnt, i < CMAX ? i : CMAX); end
      tick();
    end
    valid = '0;
    @(negedge clk);
    n_tests++; if (cnt !== CW'(CMAX)) begin n_fail++; $display("FAIL sat_final: got %0d expected %0d", cnt, CMAX); end
    tick();
  endtask

  task automatic test_random();
    int w;
    int waited[N];
    wr_t e;
    do_reset();
    for (int k = 0; k < N; k++) waited[k] = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      w = (!m_outv || !stall) ? winner() : -1;
      n_tests++; if (ready !== exp_ready()) begin n_fail++; $display("FAIL rand_ready[%0d]: got %b expected %b", c, ready, exp_ready()); end
      n_tests++; if (wr_en !== (m_outv && !stall) || wrreg_valid !== wr_en) begin n_fail++; $display("FAIL rand_en[%0d]: got %b/%b expected %b", c, wr_en, wrreg_valid, m_outv && !stall); end
      n_tests++; if (cnt !== CW'(m_cnt)) begin n_fail++; $display("FAIL rand_cnt[%0d]: got %0d expected %0d", c, cnt, m_cnt); end
      if (m_outv && !stall) begin
        n_tests++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL rand_sb[%0d]: got write expected none", c); end
        else begin
          e = sb.pop_front();
          if (wr_reg !== e.r || wrreg !== e.r || wr_data !== e.d || gid !== 2'(e.id)) begin n_fail++; $display("FAIL rand_write[%0d]: got reg=%0d data=%h id=%0d expected reg=%0d data=%h id=%0d", c, wr_reg, wr_data, gid, e.r, e.d, e.id); end
        end
      end
      if (w >= 0) begin
        for (int k = 0; k < N; k++) if (k != w && valid[k]) waited[k]++;
        for (int k = 0; k < N; k++) begin
          if (waited[k] > N - 1) begin n_tests++; n_fail++; $display("FAIL rand_starve[%0d]: got unit %0d waiting %0d grants expected <= %0d", c, k, waited[k], N - 1); waited[k] = 0; end
        end
      end
      tick();
      stall = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < N; k++) begin
        if (k == w || !valid[k]) begin
          valid[k] = 1'($urandom_range(0, 1));
          regs[k] = RW'($urandom);
          dat[k] = $urandom;
          waited[k] = 0;
        end
      end
    end
    valid = '0;
    stall = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_stall();
    test_collision();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
